// File: rtl/hamming_mem_ctrl.sv
// Hamming(7,4) protected codeword array with host read/write and correcting writeback.
// Latency: writes land at the accept edge; read data is valid 2 cycles after accept, plus 1 busy cycle when a writeback is needed.
// Backpressure: ready drops while a read or scrub owns the datapath. Optional scrubber: define HAMMING_SCRUB_EN.
module hamming_mem_ctrl #(
    parameter int ADDR_W         = 4,
    parameter int CNT_W          = 8,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wdata,
    input  logic [6:0]        inj_mask,
    input  logic              clr_cnt,
    output logic              ready,
    output logic              rd_valid,
    output logic [3:0]        rdata,
    output logic              rd_corr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic              scrub_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_WBACK = 2'd3;

    if (SCRUB_INTERVAL < 1) begin : g_bad_interval
        $error("SCRUB_INTERVAL must be >= 1");
    end

    function automatic logic [6:0] f_encode(input logic [3:0] d);
        return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d};
    endfunction

    logic [6:0]        r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_cw;
    logic              r_scrub;

    logic [2:0]        w_syn;
    logic [6:0]        w_fix;
    logic              w_err;
    logic              w_acc;
    logic              w_scrub_go;
    logic [ADDR_W-1:0] w_ptr;

    assign ready = (r_state == S_IDLE);
    assign w_acc = req && ready;

    always_comb begin
        w_syn = {r_cw[4] ^ r_cw[0] ^ r_cw[1] ^ r_cw[3],
                 r_cw[5] ^ r_cw[0] ^ r_cw[2] ^ r_cw[3],
                 r_cw[6] ^ r_cw[1] ^ r_cw[2] ^ r_cw[3]};
        w_fix = 7'b0;
        case (w_syn)
            3'b100:  w_fix = 7'b001_0000;
            3'b010:  w_fix = 7'b010_0000;
            3'b001:  w_fix = 7'b100_0000;
            3'b110:  w_fix = 7'b000_0001;
            3'b101:  w_fix = 7'b000_0010;
            3'b011:  w_fix = 7'b000_0100;
            3'b111:  w_fix = 7'b000_1000;
            default: w_fix = 7'b0;
        endcase
    end

    // Any nonzero syndrome is treated as a single-bit error; double errors miscorrect.
    assign w_err = |w_syn;

`ifdef HAMMING_SCRUB_EN
    localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);

    logic [ADDR_W-1:0] r_ptr;
    logic [TMR_W-1:0]  r_timer;

    assign w_ptr      = r_ptr;
    assign scrub_busy = r_scrub;
    // Host wins: the scrub only starts in an IDLE cycle with no request pending.
    assign w_scrub_go = (r_state == S_IDLE) && !req && (r_timer == TMR_W'(SCRUB_INTERVAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_timer <= '0;
        end else if (r_scrub && ((r_state == S_CHECK && !w_err) || r_state == S_WBACK)) begin
            r_ptr   <= r_ptr + 1'b1;
            r_timer <= '0;
        end else if (r_state == S_IDLE && !w_acc && r_timer != TMR_W'(SCRUB_INTERVAL)) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_ptr      = '0;
    assign scrub_busy = 1'b0;
    assign w_scrub_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_cw     <= '0;
            r_scrub  <= 1'b0;
            rd_valid <= 1'b0;
            rdata    <= '0;
            rd_corr  <= 1'b0;
            corr_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (we) begin
                            r_mem[addr] <= f_encode(wdata) ^ inj_mask;
                        end else begin
                            r_addr  <= addr;
                            r_scrub <= 1'b0;
                            r_state <= S_FETCH;
                        end
                    end else if (w_scrub_go) begin
                        r_addr  <= w_ptr;
                        r_scrub <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_cw    <= r_mem[r_addr];
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!r_scrub) begin
                        rd_valid <= 1'b1;
                        rdata    <= r_cw[3:0] ^ w_fix[3:0];
                        rd_corr  <= w_err;
                    end
                    if (w_err) begin
                        r_state <= S_WBACK;
                    end else begin
                        r_state <= S_IDLE;
                        r_scrub <= 1'b0;
                    end
                end
                default: begin
                    r_mem[r_addr] <= r_cw ^ w_fix;
                    r_state       <= S_IDLE;
                    r_scrub       <= 1'b0;
                end
            endcase

            if (clr_cnt) begin
                corr_cnt <= '0;
            end else if (r_state == S_CHECK && w_err && corr_cnt != {CNT_W{1'b1}}) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_mem_ctrl.sv
// Directed bench for hamming_mem_ctrl: stimulus pushes expected read responses, a negedge monitor checks them.
// Build with HAMMING_SCRUB_EN defined to exercise the scrubber instead of the host-only sequence.
module tb_hamming_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = '0;
    logic [3:0] wdata = '0;
    logic [6:0] inj_mask = '0;
    logic       clr_cnt = 1'b0;
    logic       ready;
    logic       rd_valid;
    logic [3:0] rdata;
    logic       rd_corr;
    logic [7:0] corr_cnt;
    logic       scrub_busy;

    hamming_mem_ctrl #(.ADDR_W(4), .CNT_W(8), .SCRUB_INTERVAL(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .inj_mask(inj_mask), .clr_cnt(clr_cnt), .ready(ready), .rd_valid(rd_valid),
        .rdata(rdata), .rd_corr(rd_corr), .corr_cnt(corr_cnt), .scrub_busy(scrub_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errs   = 0;

    typedef struct {
        logic [3:0] d;
        logic       c;
        int         at;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_rd_valid: rd_valid high with no read outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rdata", rdata, e.d);
                chk("rd_corr", rd_corr, e.c);
                chk("rd_latency", cyc, e.at);
            end
        end
    end

    task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d, input logic [6:0] m,
                         input bit push, input logic [3:0] ed, input logic ec);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; inj_mask = m;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: ready stayed 0 for %0d cycles, required 1", n);
        end else if (push) begin
            e.d = ed; e.c = ec; e.at = cyc + 3;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; inj_mask = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d, input logic [6:0] m);
        issue(1'b1, a, d, m, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] ed, input logic ec, input int low);
        int n;
        issue(1'b0, a, 4'h0, 7'h00, 1'b1, ed, ec);
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", n, low);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_corr", rd_corr, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_scrub_busy", scrub_busy, 0);

`ifndef HAMMING_SCRUB_EN
        rst = 1'b0;
        // Clean write/read: stored 7'h1B.
        wr(4'd3, 4'hB, 7'h00);
        rd(4'd3, 4'hB, 1'b0, 2);
        chk("cnt_after_clean", corr_cnt, 0);

        // c0 flipped (7'h1A, syndrome 110), corrected and written back.
        wr(4'd5, 4'hB, 7'h01);
        rd(4'd5, 4'hB, 1'b1, 3);
        chk("cnt_after_fix", corr_cnt, 1);
        rd(4'd5, 4'hB, 1'b0, 2);
        chk("cnt_after_reread", corr_cnt, 1);

        // Back-to-back writes then readback.
        wr(4'd10, 4'h1, 7'h00);
        wr(4'd11, 4'h2, 7'h00);
        wr(4'd12, 4'hE, 7'h00);
        rd(4'd10, 4'h1, 1'b0, 2);
        rd(4'd11, 4'h2, 1'b0, 2);
        rd(4'd12, 4'hE, 1'b0, 2);

        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        chk("cnt_cleared", corr_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            wr(4'd8, 4'h6, 7'(1 << i));
            rd(4'd8, 4'h6, 1'b1, 3);
        end
        chk("cnt_after_sweep", corr_cnt, 7);

        for (int i = 0; i < 248; i++) begin
            wr(4'd2, 4'(i), 7'h40);
            rd(4'd2, 4'(i), 1'b1, 3);
        end
        chk("cnt_at_max", corr_cnt, 255);
        wr(4'd2, 4'hA, 7'h10);
        rd(4'd2, 4'hA, 1'b1, 3);
        chk("cnt_saturated", corr_cnt, 255);
        clr_cnt = 1'b1;
        wr(4'd2, 4'h5, 7'h08);
        rd(4'd2, 4'h5, 1'b1, 3);
        clr_cnt = 1'b0;
        chk("cnt_clr_wins", corr_cnt, 0);

        // Reset while a corrupted read sits in CHECK.
        wr(4'd9, 4'hB, 7'h02);
        issue(1'b0, 4'd9, 4'h0, 7'h00, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_corr_cnt", corr_cnt, 0);
        chk("abort_rdata", rdata, 0);
        rst = 1'b0;
        rd(4'd9, 4'h0, 1'b0, 2);
        rd(4'd3, 4'h0, 1'b0, 2);
        chk("cnt_after_reset_reads", corr_cnt, 0);
`else
        // Write a corrupted word to addr 0 in the first cycle out of reset.
        rst = 1'b0;
        req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 4'hB; inj_mask = 7'h01;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; inj_mask = '0;
        n = 0;
        @(negedge clk);
        while (!scrub_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("scrub_start_delay", n, 5);
        n = 0;
        while (scrub_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("scrub_busy_cycles", n, 3);
        chk("scrub_cnt", corr_cnt, 1);
        // Request arrives in the cycle the timer expires; the host must go first.
        repeat (3) @(negedge clk);
        chk("pre_expiry_busy", scrub_busy, 0);
        rd(4'd0, 4'hB, 1'b0, 2);
        @(negedge clk);
        chk("scrub_after_host", scrub_busy, 1);
        n = 0;
        while (scrub_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("scrub_clean_cycles", n, 2);
        chk("cnt_after_clean_scrub", corr_cnt, 1);
`endif

        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
